// File: rtl/scan_chain_driver.sv
`default_nettype none
// ============================================================================
// Module   : scan_chain_driver
// Purpose  : Loads a pattern into a scan chain while unloading its previous
//            contents, then drops SE for a functional capture window.
//            Optional compare logic is enabled with `define SCAN_CMP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module scan_chain_driver #(
    parameter int CHAIN_LEN = 16,
    parameter int CAP_CYC   = 1
) (
    input  logic                 CK,
    input  logic                 RN,
    input  logic                 start,
    input  logic [CHAIN_LEN-1:0] pattern_in,
    output logic                 busy,
    output logic                 done,
    output logic [CHAIN_LEN-1:0] resp_out,
    output logic                 SE,
    output logic                 SI,
`ifdef SCAN_CMP_EN
    input  logic [CHAIN_LEN-1:0] exp_in,
    input  logic [CHAIN_LEN-1:0] mask_in,
    output logic                 fail,
`endif
    input  logic                 SO
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int CAP_W = (CAP_CYC > 1) ? $clog2(CAP_CYC) : 1;
    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CAP_W-1:0] LAST_CAP   = CAP_W'(CAP_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SHIFT   = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    state_t               state_q;
    logic [CNT_W-1:0]     shift_cnt_q;
    logic [CAP_W-1:0]     cap_cnt_q;
    logic [CHAIN_LEN-1:0] pat_q;
    logic [CHAIN_LEN-2:0] unload_q;
    logic [CHAIN_LEN-1:0] unload_d;
    logic [CHAIN_LEN-1:0] resp_q;
    logic                 se_q;
    logic                 si_q;
    logic                 busy_q;
    logic                 done_q;
`ifdef SCAN_CMP_EN
    logic [CHAIN_LEN-1:0] exp_q;
    logic [CHAIN_LEN-1:0] mask_q;
    logic                 fail_q;
`endif

    // The first SO sample is the tail flop, so it ends up in the MSB.
    assign unload_d = {unload_q, SO};

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state_q     <= ST_IDLE;
            shift_cnt_q <= '0;
            cap_cnt_q   <= '0;
            pat_q       <= '0;
            unload_q    <= '0;
            resp_q      <= '0;
            se_q        <= 1'b0;
            si_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef SCAN_CMP_EN
            exp_q       <= '0;
            mask_q      <= '0;
            fail_q      <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        // MSB goes out immediately; the shadow keeps the rest left-aligned.
                        pat_q       <= {pattern_in[CHAIN_LEN-2:0], 1'b0};
                        si_q        <= pattern_in[CHAIN_LEN-1];
                        shift_cnt_q <= '0;
                        se_q        <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= ST_SHIFT;
`ifdef SCAN_CMP_EN
                        exp_q       <= exp_in;
                        mask_q      <= mask_in;
                        fail_q      <= 1'b0;
`endif
                    end
                end
                ST_SHIFT: begin
                    unload_q    <= unload_d[CHAIN_LEN-2:0];
                    pat_q       <= {pat_q[CHAIN_LEN-2:0], 1'b0};
                    shift_cnt_q <= shift_cnt_q + CNT_W'(1);
                    if (shift_cnt_q == LAST_SHIFT) begin
                        resp_q    <= unload_d;
                        se_q      <= 1'b0;
                        si_q      <= 1'b0;
                        cap_cnt_q <= '0;
                        state_q   <= ST_CAPTURE;
`ifdef SCAN_CMP_EN
                        fail_q    <= |((unload_d ^ exp_q) & mask_q);
`endif
                    end else begin
                        si_q <= pat_q[CHAIN_LEN-1];
                    end
                end
                ST_CAPTURE: begin
                    if (cap_cnt_q == LAST_CAP) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        cap_cnt_q <= cap_cnt_q + CAP_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign resp_out = resp_q;
    assign SE       = se_q;
    assign SI       = si_q;
`ifdef SCAN_CMP_EN
    assign fail     = fail_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_scan_chain_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_scan_chain_driver
// Purpose  : Randomized scoreboard bench for scan_chain_driver with a
//            behavioural 16-flop scan chain (SCAN_CMP_EN selects CAP_CYC=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_scan_chain_driver;

    localparam int N = 16;
`ifdef SCAN_CMP_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic         CK = 1'b0;
    logic         RN;
    logic         start;
    logic [N-1:0] pattern_in;
    logic         busy;
    logic         done;
    logic [N-1:0] resp_out;
    logic         SE;
    logic         SI;
    logic         SO;
    logic [N-1:0] exp_in;
    logic [N-1:0] mask_in;
`ifdef SCAN_CMP_EN
    logic         fail_o;
`endif

    logic [N-1:0] chain;
    logic [N-1:0] func_d;
    logic [N-1:0] cur_fd;

    typedef struct {
        logic [N-1:0] resp;
        logic [N-1:0] pat;
        logic [N-1:0] fd;
        logic         fl;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    scan_chain_driver #(.CHAIN_LEN(N), .CAP_CYC(CAP)) dut (
        .CK        (CK),
        .RN        (RN),
        .start     (start),
        .pattern_in(pattern_in),
        .busy      (busy),
        .done      (done),
        .resp_out  (resp_out),
        .SE        (SE),
        .SI        (SI),
`ifdef SCAN_CMP_EN
        .exp_in    (exp_in),
        .mask_in   (mask_in),
        .fail      (fail_o),
`endif
        .SO        (SO)
    );

    always #5 CK = ~CK;

    // Behavioural chain: shift when SE, otherwise capture functional D.
    assign SO = chain[N-1];
    always @(posedge CK) chain <= SE ? {chain[N-2:0], SI} : func_d;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Monitor: counts SE/busy cycles, snapshots the chain at SE fall, checks at done.
    int           se_cnt;
    int           busy_cnt;
    logic         prev_se;
    logic [N-1:0] snap;
    exp_t         mon_e;

    always @(negedge CK) begin
        if (!RN) begin
            se_cnt   = 0;
            busy_cnt = 0;
            prev_se  = 1'b0;
        end else begin
            if (prev_se && !SE) snap = chain;
            prev_se = SE;
            if (SE)   se_cnt++;
            if (busy) busy_cnt++;
            if (done) begin
                check("sb_nonempty_at_done", (sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    mon_e = sb.pop_front();
                    check("resp_out", resp_out, mon_e.resp);
                    check("chain_after_shift", snap, mon_e.pat);
                    check("chain_after_capture", chain, mon_e.fd);
                    check("se_high_cycles", se_cnt, N);
                    check("busy_cycles", busy_cnt, N + CAP);
`ifdef SCAN_CMP_EN
                    check("fail_flag", fail_o, mon_e.fl);
`endif
                end
                se_cnt   = 0;
                busy_cnt = 0;
            end
        end
    end

    // Called just after a negedge where the DUT is idle or showing done.
    task automatic issue(input logic [N-1:0] pat, input logic [N-1:0] fd,
                         input logic [N-1:0] ex, input logic [N-1:0] mk);
        exp_t e;
        start      = 1'b1;
        pattern_in = pat;
        exp_in     = ex;
        mask_in    = mk;
        e.resp = cur_fd;
        e.pat  = pat;
        e.fd   = fd;
        e.fl   = |((cur_fd ^ ex) & mk);
        sb.push_back(e);
        @(negedge CK);
        start      = 1'b0;
        pattern_in = N'($urandom);
        exp_in     = N'($urandom);
        mask_in    = N'($urandom);
        func_d     = fd;
        cur_fd     = fd;
        check("busy_after_start", busy, 1);
`ifdef SCAN_CMP_EN
        check("fail_cleared_on_start", fail_o, 0);
`endif
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        do begin
            @(negedge CK);
            k++;
        end while (!done && k < 200);
        if (!done) begin
            n_chk++;
            n_fail++;
            $display("FAIL done_timeout: got done=0 after %0d cycles expected done=1", k);
        end
    endtask

    int           gap;
    logic [N-1:0] ex_r;

    initial begin
        RN         = 1'b0;
        start      = 1'b1;
        pattern_in = 16'hFFFF;
        exp_in     = '0;
        mask_in    = '0;
        func_d     = 16'hBEEF;
        cur_fd     = 16'hBEEF;

        repeat (4) begin
            @(negedge CK);
            check("reset_SE", SE, 0);
            check("reset_SI", SI, 0);
            check("reset_busy", busy, 0);
            check("reset_done", done, 0);
            check("reset_resp", resp_out, 16'h0000);
        end
        check("reset_chain_no_shift", chain, 16'hBEEF);
        start = 1'b0;
        RN    = 1'b1;
        @(negedge CK);

        // Basic op, then back-to-back ops exercising unload of capture and compare.
        issue(16'hA5C3, 16'h1234, 16'h0000, 16'h0000);
        wait_done();
        issue(16'h0000, 16'h1234, 16'h1234, 16'hFFFF);
        wait_done();
        issue(16'h6B2D, 16'h1234, 16'h1235, 16'hFFFF);
        wait_done();
        issue(16'h9E17, 16'h4C71, 16'h1235, 16'hFFFE);
        wait_done();

        // Start pulse while busy must be ignored.
        @(negedge CK);
        issue(16'h5A69, 16'h0F0F, 16'h0000, 16'h0000);
        repeat (4) @(posedge CK);
        @(negedge CK);
        start      = 1'b1;
        pattern_in = 16'hFFFF;
        @(negedge CK);
        start      = 1'b0;
        wait_done();
        repeat (3) begin
            @(negedge CK);
            check("no_second_done", done, 0);
        end

        // Asynchronous reset after edge t5 of SHIFT.
        issue(16'h3C5A, 16'h7E81, 16'h0000, 16'h0000);
        repeat (5) @(posedge CK);
        #1 RN = 1'b0;
        #1;
        check("midreset_SE", SE, 0);
        check("midreset_busy", busy, 0);
        check("midreset_SI", SI, 0);
        check("midreset_resp", resp_out, 16'h0000);
        sb.delete();
        @(negedge CK);
        @(negedge CK);
        RN = 1'b1;
        @(negedge CK);
        issue(16'h00FF, 16'hC3A5, 16'h0000, 16'h0000);
        wait_done();

        // Randomized ops, mixing back-to-back and idle gaps.
        for (int i = 0; i < 20; i++) begin
            gap = $urandom_range(0, 3);
            repeat (gap) @(negedge CK);
            ex_r = ($urandom_range(0, 1) == 1) ? cur_fd : N'($urandom);
            issue(N'($urandom), N'($urandom), ex_r, N'($urandom));
            wait_done();
        end

        repeat (4) @(negedge CK);
        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
